// File: rtl/cacheline_adapter_if.sv
// Bus bundle between the cache (dfp_*) and burst memory (bmem_*) sides of the
// cacheline adapter.
interface cacheline_adapter_if #(
  parameter int LINE_BITS  = 256,
  parameter int BURST_BITS = 64
);
  logic [31:0]           dfp_addr;
  logic                  dfp_read;
  logic                  dfp_write;
  logic [LINE_BITS-1:0]  dfp_wdata;
  logic [LINE_BITS-1:0]  dfp_rdata;
  logic                  dfp_resp;

  logic [31:0]           bmem_addr;
  logic                  bmem_read;
  logic                  bmem_write;
  logic [BURST_BITS-1:0] bmem_wdata;
  logic                  bmem_ready;
  logic [BURST_BITS-1:0] bmem_rdata;
  logic                  bmem_rvalid;

  // slave: the adapter itself; master: whatever drives the cache and memory sides
  modport slave (
    input  dfp_addr, dfp_read, dfp_write, dfp_wdata,
    output dfp_rdata, dfp_resp,
    output bmem_addr, bmem_read, bmem_write, bmem_wdata,
    input  bmem_ready, bmem_rdata, bmem_rvalid
  );

  modport master (
    output dfp_addr, dfp_read, dfp_write, dfp_wdata,
    input  dfp_rdata, dfp_resp,
    input  bmem_addr, bmem_read, bmem_write, bmem_wdata,
    output bmem_ready, bmem_rdata, bmem_rvalid
  );
endinterface

// File: rtl/cacheline_adapter.sv
// Converts single-cycle cacheline fill/writeback requests into BEATS-long
// memory bursts and assembles/slices the line around them.
module cacheline_adapter #(
  parameter int LINE_BITS  = 256,
  parameter int BURST_BITS = 64
) (
  input  logic                clk,
  input  logic                rst,
  cacheline_adapter_if.slave  bus
);
  localparam int BEATS = LINE_BITS / BURST_BITS;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFF_W = $clog2(LINE_BITS / 8);
  localparam logic [31:0]      ADDR_MASK = ~((32'd1 << OFF_W) - 32'd1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [2:0] {
    IDLE,
    READ_REQ,
    READ_BURST,
    WRITE_BURST,
    RESP
  } state_t;

  typedef logic [BEATS-1:0][BURST_BITS-1:0] line_t;

  // Latched request; data is only meaningful for writebacks.
  typedef struct packed {
    logic [31:0] addr;
    line_t       data;
  } req_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  req_t             req_q, req_d;
  line_t            line_q, line_d;

  logic                  dfp_resp_o;
  logic                  bmem_read_o;
  logic                  bmem_write_o;
  logic [31:0]           bmem_addr_o;
  logic [BURST_BITS-1:0] bmem_wdata_o;
  logic [LINE_BITS-1:0]  dfp_rdata_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      line_q  <= line_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_d        = req_q;
    line_d       = line_q;
    dfp_resp_o   = 1'b0;
    bmem_read_o  = 1'b0;
    bmem_write_o = 1'b0;
    bmem_addr_o  = '0;
    bmem_wdata_o = '0;

    case (state_q)
      IDLE: begin
        if (bus.dfp_read) begin
          req_d.addr = bus.dfp_addr & ADDR_MASK;
          state_d    = READ_REQ;
        end else if (bus.dfp_write) begin
          req_d.addr = bus.dfp_addr & ADDR_MASK;
          req_d.data = bus.dfp_wdata;
          state_d    = WRITE_BURST;
        end
      end
      READ_REQ: begin
        bmem_read_o = 1'b1;
        bmem_addr_o = req_q.addr;
        if (bus.bmem_ready) begin
          cnt_d   = '0;
          state_d = READ_BURST;
        end
      end
      READ_BURST: begin
        if (bus.bmem_rvalid) begin
          line_d[cnt_q] = bus.bmem_rdata;
          cnt_d         = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) state_d = RESP;
        end
      end
      WRITE_BURST: begin
        bmem_write_o = 1'b1;
        bmem_addr_o  = req_q.addr;
        bmem_wdata_o = req_q.data[cnt_q];
        if (bus.bmem_ready) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) state_d = RESP;
        end
      end
      RESP: begin
        dfp_resp_o = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are forced low during reset even before the state register clears.
  assign dfp_rdata_o    = rst ? '0 : LINE_BITS'(line_q);
  assign bus.dfp_rdata  = dfp_rdata_o;
  assign bus.dfp_resp   = dfp_resp_o   & ~rst;
  assign bus.bmem_read  = bmem_read_o  & ~rst;
  assign bus.bmem_write = bmem_write_o & ~rst;
  assign bus.bmem_addr  = rst ? '0 : bmem_addr_o;
  assign bus.bmem_wdata = rst ? '0 : bmem_wdata_o;
endmodule

// File: tb/tb_cacheline_adapter.sv
// Directed bench for cacheline_adapter: cycle tables for fill/writeback plus
// hand sequences for stalls, read/write collision and mid-burst reset.
module tb_cacheline_adapter;
  localparam int LB = 256;
  localparam int BB = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cacheline_adapter_if #(.LINE_BITS(LB), .BURST_BITS(BB)) bus();
  cacheline_adapter #(.LINE_BITS(LB), .BURST_BITS(BB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  int resp_cnt = 0;
  int wr_cnt   = 0;
  int ovl_cnt  = 0;

  always @(negedge clk) begin
    if (bus.dfp_resp === 1'b1) resp_cnt <= resp_cnt + 1;
    if (bus.bmem_write === 1'b1) wr_cnt <= wr_cnt + 1;
    if (bus.bmem_read === 1'b1 && bus.bmem_write === 1'b1) ovl_cnt <= ovl_cnt + 1;
  end

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rd, wr, ready, rvalid;
    logic [63:0] rdata;
    logic        e_read, e_write, e_resp;
    logic [31:0] e_addr;
    logic [63:0] e_wdata;
  } vec_t;

  function automatic vec_t mk(input logic rd, wr, ready, rvalid, input logic [63:0] rdata,
                              input logic e_read, e_write, e_resp,
                              input logic [31:0] e_addr, input logic [63:0] e_wdata);
    vec_t v;
    v.rd = rd; v.wr = wr; v.ready = ready; v.rvalid = rvalid; v.rdata = rdata;
    v.e_read = e_read; v.e_write = e_write; v.e_resp = e_resp;
    v.e_addr = e_addr; v.e_wdata = e_wdata;
    return v;
  endfunction

  localparam int NV = 19;
  vec_t vt [NV];

  localparam logic [63:0] B1 = 64'h1111_1111_1111_1111, B2 = 64'h2222_2222_2222_2222;
  localparam logic [63:0] B3 = 64'h3333_3333_3333_3333, B4 = 64'h4444_4444_4444_4444;
  localparam logic [63:0] WA = 64'hAAAA_AAAA_AAAA_AAAA, WB = 64'hBBBB_BBBB_BBBB_BBBB;
  localparam logic [63:0] WC = 64'hCCCC_CCCC_CCCC_CCCC, WD = 64'hDDDD_DDDD_DDDD_DDDD;

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      step();
      bus.dfp_read    = vt[i].rd;
      bus.dfp_write   = vt[i].wr;
      bus.bmem_ready  = vt[i].ready;
      bus.bmem_rvalid = vt[i].rvalid;
      bus.bmem_rdata  = vt[i].rdata;
      @(negedge clk);
      chk($sformatf("v%0d bmem_read", i),  256'(bus.bmem_read),  256'(vt[i].e_read));
      chk($sformatf("v%0d bmem_write", i), 256'(bus.bmem_write), 256'(vt[i].e_write));
      chk($sformatf("v%0d dfp_resp", i),   256'(bus.dfp_resp),   256'(vt[i].e_resp));
      if (vt[i].e_read || vt[i].e_write)
        chk($sformatf("v%0d bmem_addr", i), 256'(bus.bmem_addr), 256'(vt[i].e_addr));
      if (vt[i].e_write)
        chk($sformatf("v%0d bmem_wdata", i), 256'(bus.bmem_wdata), 256'(vt[i].e_wdata));
    end
  endtask

  // Fixed-timing fill: ready at once, beats back-to-back from the first burst cycle.
  task automatic run_read(input string nm, input logic [31:0] a, input logic w, input logic [255:0] l);
    step();
    bus.dfp_read = 1'b1; bus.dfp_write = w; bus.dfp_addr = a;
    bus.bmem_ready = 1'b1; bus.bmem_rvalid = 1'b0;
    step();
    @(negedge clk);
    chk({nm, " bmem_read"},  256'(bus.bmem_read), 256'(1));
    chk({nm, " bmem_write"}, 256'(bus.bmem_write), 256'(0));
    chk({nm, " bmem_addr"},  256'(bus.bmem_addr), 256'(a & 32'hFFFF_FFE0));
    step();
    bus.bmem_ready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      bus.bmem_rvalid = 1'b1;
      bus.bmem_rdata  = l[b*64 +: 64];
      step();
    end
    bus.bmem_rvalid = 1'b0;
    @(negedge clk);
    chk({nm, " dfp_resp"}, 256'(bus.dfp_resp), 256'(1));
    step();
    bus.dfp_read = 1'b0; bus.dfp_write = 1'b0;
    @(negedge clk);
    chk({nm, " dfp_rdata"}, bus.dfp_rdata, l);
  endtask

  logic [255:0] fill_line, wline, stall_line, sim_line, rec_line;
  int r0, w0;

  initial begin
    fill_line  = {B4, B3, B2, B1};
    wline      = {WD, WC, WB, WA};
    stall_line = {64'hD4D4_D4D4_D4D4_D4D4, 64'hC3C3_C3C3_C3C3_C3C3,
                  64'hB2B2_B2B2_B2B2_B2B2, 64'hA1A1_A1A1_A1A1_A1A1};
    sim_line   = {64'h0F0F_0F0F_0000_0004, 64'h0F0F_0F0F_0000_0003,
                  64'h0F0F_0F0F_0000_0002, 64'h0F0F_0F0F_0000_0001};
    rec_line   = {64'h9876_5432_1000_0004, 64'h9876_5432_1000_0003,
                  64'h9876_5432_1000_0002, 64'h9876_5432_1000_0001};

    // read fill: cycle 0 request, cycle 1 command, beats 3..6, resp at 7
    vt[0]  = mk(1,0,0,0,64'h0, 0,0,0, 32'h0, 64'h0);
    vt[1]  = mk(1,0,1,0,64'h0, 1,0,0, 32'h0000_1220, 64'h0);
    vt[2]  = mk(1,0,0,0,64'h0, 0,0,0, 32'h0, 64'h0);
    vt[3]  = mk(1,0,0,1,B1,    0,0,0, 32'h0, 64'h0);
    vt[4]  = mk(1,0,0,1,B2,    0,0,0, 32'h0, 64'h0);
    vt[5]  = mk(1,0,0,1,B3,    0,0,0, 32'h0, 64'h0);
    vt[6]  = mk(1,0,0,1,B4,    0,0,0, 32'h0, 64'h0);
    vt[7]  = mk(1,0,0,0,64'h0, 0,0,1, 32'h0, 64'h0);
    vt[8]  = mk(0,0,0,0,64'h0, 0,0,0, 32'h0, 64'h0);
    // writeback with ready toggling 1/0; stray rvalid must be ignored
    vt[9]  = mk(0,1,0,0,64'h0, 0,0,0, 32'h0, 64'h0);
    vt[10] = mk(0,1,1,1,B1,    0,1,0, 32'h0000_1220, WA);
    vt[11] = mk(0,1,0,0,64'h0, 0,1,0, 32'h0000_1220, WB);
    vt[12] = mk(0,1,1,0,64'h0, 0,1,0, 32'h0000_1220, WB);
    vt[13] = mk(0,1,0,0,64'h0, 0,1,0, 32'h0000_1220, WC);
    vt[14] = mk(0,1,1,0,64'h0, 0,1,0, 32'h0000_1220, WC);
    vt[15] = mk(0,1,0,0,64'h0, 0,1,0, 32'h0000_1220, WD);
    vt[16] = mk(0,1,1,0,64'h0, 0,1,0, 32'h0000_1220, WD);
    vt[17] = mk(0,1,0,0,64'h0, 0,0,1, 32'h0, 64'h0);
    vt[18] = mk(0,0,0,0,64'h0, 0,0,0, 32'h0, 64'h0);

    rst = 1'b1;
    bus.dfp_addr = 32'h0000_1234; bus.dfp_read = 1'b0; bus.dfp_write = 1'b0;
    bus.dfp_wdata = wline;
    bus.bmem_ready = 1'b0; bus.bmem_rdata = '0; bus.bmem_rvalid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst dfp_resp",   256'(bus.dfp_resp), 256'(0));
    chk("rst bmem_read",  256'(bus.bmem_read), 256'(0));
    chk("rst bmem_write", 256'(bus.bmem_write), 256'(0));
    chk("rst bmem_addr",  256'(bus.bmem_addr), 256'(0));
    chk("rst bmem_wdata", 256'(bus.bmem_wdata), 256'(0));
    chk("rst dfp_rdata",  bus.dfp_rdata, 256'(0));
    step();
    rst = 1'b0;

    run_vecs(0, 8);
    chk("fill dfp_rdata", bus.dfp_rdata, fill_line);
    run_vecs(9, 18);
    chk("fill rdata kept across write", bus.dfp_rdata, fill_line);

    // stalled read: ready after 3 cycles, gap between beats, request inputs scrambled
    r0 = resp_cnt;
    step();
    bus.dfp_read = 1'b1; bus.dfp_addr = 32'h0000_5678; bus.bmem_ready = 1'b0;
    step();
    bus.dfp_addr = 32'hFFFF_FFFF; bus.dfp_wdata = ~wline; bus.dfp_write = 1'b1;
    @(negedge clk);
    chk("stall bmem_read c1", 256'(bus.bmem_read), 256'(1));
    chk("stall bmem_addr",    256'(bus.bmem_addr), 256'(32'h0000_5660));
    chk("stall rdata held",   bus.dfp_rdata, fill_line);
    step(); @(negedge clk);
    chk("stall bmem_read c2", 256'(bus.bmem_read), 256'(1));
    step(); @(negedge clk);
    chk("stall bmem_read c3", 256'(bus.bmem_read), 256'(1));
    step(); bus.bmem_ready = 1'b1; @(negedge clk);
    chk("stall bmem_read c4", 256'(bus.bmem_read), 256'(1));
    step(); bus.bmem_ready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      step(); bus.bmem_rvalid = 1'b1; bus.bmem_rdata = stall_line[b*64 +: 64];
      step(); bus.bmem_rvalid = 1'b0;
    end
    @(negedge clk);
    chk("stall dfp_resp", 256'(bus.dfp_resp), 256'(1));
    step(); bus.dfp_read = 1'b0; bus.dfp_write = 1'b0;
    step(); @(negedge clk);
    chk("stall resp count", 256'(resp_cnt - r0), 256'(1));
    chk("stall dfp_rdata",  bus.dfp_rdata, stall_line);

    // read and write together: read wins, no write beats
    w0 = wr_cnt;
    run_read("both", 32'h0000_9ABC, 1'b1, sim_line);
    chk("both no bmem_write", 256'(wr_cnt - w0), 256'(0));

    // reset after 2 of 4 beats, then stray beats in IDLE
    r0 = resp_cnt;
    step();
    bus.dfp_read = 1'b1; bus.dfp_addr = 32'h0000_1234; bus.bmem_ready = 1'b1;
    step();
    step(); bus.bmem_ready = 1'b0; bus.bmem_rvalid = 1'b1; bus.bmem_rdata = B1;
    step(); bus.bmem_rdata = B2;
    step(); rst = 1'b1; bus.dfp_read = 1'b0; bus.bmem_rdata = B3;
    @(negedge clk);
    chk("mid rst dfp_resp",   256'(bus.dfp_resp), 256'(0));
    chk("mid rst bmem_read",  256'(bus.bmem_read), 256'(0));
    chk("mid rst bmem_write", 256'(bus.bmem_write), 256'(0));
    chk("mid rst bmem_addr",  256'(bus.bmem_addr), 256'(0));
    chk("mid rst bmem_wdata", 256'(bus.bmem_wdata), 256'(0));
    chk("mid rst dfp_rdata",  bus.dfp_rdata, 256'(0));
    step(); rst = 1'b0; bus.bmem_rdata = B4;
    step(); step(); bus.bmem_rvalid = 1'b0;
    @(negedge clk);
    chk("post rst no resp",   256'(resp_cnt - r0), 256'(0));
    chk("post rst dfp_rdata", bus.dfp_rdata, 256'(0));
    chk("post rst bmem_read", 256'(bus.bmem_read), 256'(0));
    run_read("recover", 32'h0000_4321, 1'b0, rec_line);
    step(); @(negedge clk);
    chk("recover resp count", 256'(resp_cnt - r0), 256'(1));
    chk("read/write overlap", 256'(ovl_cnt), 256'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
